// File: rtl/tap_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tap_fsm_ctrl
// Brief    : IEEE 1149.1 TAP controller. Tracks the 16-state TAP machine
//            from TMS, decodes the IR/DR capture/shift/update strobes, and
//            drives the TDO mux Select (1 = IR, 0 = DR) and TDO_En.
//            TDO_NEG_EDGE=1 registers Select/TDO_En on the TCK falling edge;
//            TDO_NEG_EDGE=0 decodes them combinationally from the state.
//            Optional macro TAP_STATE_DEBUG_EN adds the State_dbg and
//            Tms_Ones observation ports.
// Revision : 1.0 - initial release
// ============================================================================
module tap_fsm_ctrl #(
  parameter bit TDO_NEG_EDGE = 1'b1
) (
  input  logic       TCK,
  input  logic       TRST_n,
  input  logic       TMS,
  output logic       Select,
  output logic       TDO_En,
  output logic       Capture_DR,
  output logic       Shift_DR,
  output logic       Update_DR,
  output logic       Capture_IR,
  output logic       Shift_IR,
  output logic       Update_IR,
`ifdef TAP_STATE_DEBUG_EN
  output logic [3:0] State_dbg,
  output logic [2:0] Tms_Ones,
`endif
  output logic       Test_Reset
);

  // Standard 1149.1 state codes
  localparam logic [3:0] S_TLR    = 4'hF;
  localparam logic [3:0] S_RTI    = 4'hC;
  localparam logic [3:0] S_SELDR  = 4'h7;
  localparam logic [3:0] S_CAPDR  = 4'h6;
  localparam logic [3:0] S_SHDR   = 4'h2;
  localparam logic [3:0] S_EX1DR  = 4'h1;
  localparam logic [3:0] S_PAUDR  = 4'h3;
  localparam logic [3:0] S_EX2DR  = 4'h0;
  localparam logic [3:0] S_UPDDR  = 4'h5;
  localparam logic [3:0] S_SELIR  = 4'h4;
  localparam logic [3:0] S_CAPIR  = 4'hE;
  localparam logic [3:0] S_SHIR   = 4'hA;
  localparam logic [3:0] S_EX1IR  = 4'h9;
  localparam logic [3:0] S_PAUIR  = 4'hB;
  localparam logic [3:0] S_EX2IR  = 4'h8;
  localparam logic [3:0] S_UPDIR  = 4'hD;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       select_d;
  logic       tdo_en_d;

  // State register: TRST_n forces Test-Logic-Reset immediately, without TCK
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      state_q <= S_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode from TMS
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TLR:   state_d = TMS ? S_TLR   : S_RTI;
      S_RTI:   state_d = TMS ? S_SELDR : S_RTI;
      S_SELDR: state_d = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: state_d = TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  state_d = TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: state_d = TMS ? S_UPDDR : S_PAUDR;
      S_PAUDR: state_d = TMS ? S_EX2DR : S_PAUDR;
      S_EX2DR: state_d = TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: state_d = TMS ? S_SELDR : S_RTI;
      S_SELIR: state_d = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: state_d = TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  state_d = TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: state_d = TMS ? S_UPDIR : S_PAUIR;
      S_PAUIR: state_d = TMS ? S_EX2IR : S_PAUIR;
      S_EX2IR: state_d = TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: state_d = TMS ? S_SELDR : S_RTI;
      default: state_d = S_TLR;
    endcase
  end

  // Output decode: strobes plus the Select/TDO_En source terms
  always_comb begin
    Capture_DR = (state_q == S_CAPDR);
    Shift_DR   = (state_q == S_SHDR);
    Update_DR  = (state_q == S_UPDDR);
    Capture_IR = (state_q == S_CAPIR);
    Shift_IR   = (state_q == S_SHIR);
    Update_IR  = (state_q == S_UPDIR);
    Test_Reset = (state_q == S_TLR);
    // SelIR is excluded: the IR path is not yet committed there
    select_d   = (state_q == S_CAPIR) || (state_q == S_SHIR)  ||
                 (state_q == S_EX1IR) || (state_q == S_PAUIR) ||
                 (state_q == S_EX2IR) || (state_q == S_UPDIR);
    tdo_en_d   = (state_q == S_SHDR) || (state_q == S_SHIR);
  end

  generate
    if (TDO_NEG_EDGE) begin : g_tdo_negedge
      logic select_q;
      logic tdo_en_q;

      // Falling-edge retiming so TDO changes half a cycle after the state
      always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
          select_q <= 1'b0;
          tdo_en_q <= 1'b0;
        end else begin
          select_q <= select_d;
          tdo_en_q <= tdo_en_d;
        end
      end

      assign Select = select_q;
      assign TDO_En = tdo_en_q;
    end else begin : g_tdo_comb
      assign Select = select_d;
      assign TDO_En = tdo_en_d;
    end
  endgenerate

`ifdef TAP_STATE_DEBUG_EN
  logic [2:0] tms_ones_q;
  logic [2:0] tms_ones_d;

  // Consecutive TMS=1 counter, saturating at 5 (the TLR guarantee depth)
  always_comb begin
    tms_ones_d = 3'd0;
    if (TMS) begin
      tms_ones_d = (tms_ones_q >= 3'd5) ? 3'd5 : (tms_ones_q + 3'd1);
    end
  end

  // Counter register, cleared together with the state on TRST_n
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n) begin
      tms_ones_q <= 3'd0;
    end else begin
      tms_ones_q <= tms_ones_d;
    end
  end

  assign State_dbg = state_q;
  assign Tms_Ones  = tms_ones_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tap_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_fsm_ctrl
// Brief    : Self-checking bench for tap_fsm_ctrl. A path/phase model of the
//            TAP machine predicts every output each half cycle; literal
//            pulse counts pin the model for the directed sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tap_fsm_ctrl;

  localparam bit NEG = 1'b1;

  // Model phases, shared by the DR and IR columns
  localparam int K_TLR = 0;
  localparam int K_RTI = 1;
  localparam int K_SEL = 2;
  localparam int K_CAP = 3;
  localparam int K_SH  = 4;
  localparam int K_EX1 = 5;
  localparam int K_PAU = 6;
  localparam int K_EX2 = 7;
  localparam int K_UPD = 8;

  logic TCK;
  logic TRST_n;
  logic TMS;
  logic Select, TDO_En, Capture_DR, Shift_DR, Update_DR;
  logic Capture_IR, Shift_IR, Update_IR, Test_Reset;
`ifdef TAP_STATE_DEBUG_EN
  logic [3:0] State_dbg;
  logic [2:0] Tms_Ones;
`endif

  tap_fsm_ctrl #(.TDO_NEG_EDGE(NEG)) dut (
    .TCK        (TCK),
    .TRST_n     (TRST_n),
    .TMS        (TMS),
    .Select     (Select),
    .TDO_En     (TDO_En),
    .Capture_DR (Capture_DR),
    .Shift_DR   (Shift_DR),
    .Update_DR  (Update_DR),
    .Capture_IR (Capture_IR),
    .Shift_IR   (Shift_IR),
    .Update_IR  (Update_IR),
`ifdef TAP_STATE_DEBUG_EN
    .State_dbg  (State_dbg),
    .Tms_Ones   (Tms_Ones),
`endif
    .Test_Reset (Test_Reset)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  int errors = 0;
  int checks = 0;

  // Model state: which column (0 DR, 1 IR) and which phase
  int m_kind = K_TLR;
  bit m_ir   = 1'b0;
  int m_ones = 0;

  // Pulse counters observed on the DUT
  int n_cap_dr, n_sh_dr, n_upd_dr, n_cap_ir, n_sh_ir, n_upd_ir, n_en, n_sel;

  logic [7:0] path_bits [16];
  int         path_len  [16];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit m_sel();
    return m_ir && (m_kind >= K_CAP);
  endfunction

  function automatic bit m_en();
    return m_kind == K_SH;
  endfunction

  // Spec state code for a (column, phase) pair
  function automatic logic [3:0] m_code();
    case (m_kind)
      K_TLR:   return 4'hF;
      K_RTI:   return 4'hC;
      K_SEL:   return m_ir ? 4'h4 : 4'h7;
      K_CAP:   return m_ir ? 4'hE : 4'h6;
      K_SH:    return m_ir ? 4'hA : 4'h2;
      K_EX1:   return m_ir ? 4'h9 : 4'h1;
      K_PAU:   return m_ir ? 4'hB : 4'h3;
      K_EX2:   return m_ir ? 4'h8 : 4'h0;
      default: return m_ir ? 4'hD : 4'h5;
    endcase
  endfunction

  task automatic m_reset();
    m_kind = K_TLR;
    m_ir   = 1'b0;
    m_ones = 0;
  endtask

  task automatic m_adv(input bit t);
    m_ones = t ? ((m_ones >= 5) ? 5 : m_ones + 1) : 0;
    case (m_kind)
      K_TLR: if (!t) m_kind = K_RTI;
      K_RTI: if (t) begin m_kind = K_SEL; m_ir = 1'b0; end
      K_SEL: begin
        if (!t)       m_kind = K_CAP;
        else if (!m_ir) m_ir = 1'b1;
        else begin m_kind = K_TLR; m_ir = 1'b0; end
      end
      K_CAP, K_SH: m_kind = t ? K_EX1 : K_SH;
      K_EX1: m_kind = t ? K_UPD : K_PAU;
      K_PAU: m_kind = t ? K_EX2 : K_PAU;
      K_EX2: m_kind = t ? K_UPD : K_SH;
      default: begin
        if (t) begin m_kind = K_SEL; m_ir = 1'b0; end
        else m_kind = K_RTI;
      end
    endcase
  endtask

  // Compare every DUT output against the model
  task automatic check_outputs(input bit exp_sel, input bit exp_en);
    chk("Capture_DR", Capture_DR, (m_kind == K_CAP) && !m_ir);
    chk("Shift_DR",   Shift_DR,   (m_kind == K_SH)  && !m_ir);
    chk("Update_DR",  Update_DR,  (m_kind == K_UPD) && !m_ir);
    chk("Capture_IR", Capture_IR, (m_kind == K_CAP) && m_ir);
    chk("Shift_IR",   Shift_IR,   (m_kind == K_SH)  && m_ir);
    chk("Update_IR",  Update_IR,  (m_kind == K_UPD) && m_ir);
    chk("Test_Reset", Test_Reset, m_kind == K_TLR);
    chk("Select",     Select,     exp_sel);
    chk("TDO_En",     TDO_En,     exp_en);
`ifdef TAP_STATE_DEBUG_EN
    checks++;
    if (State_dbg !== m_code()) begin
      errors++;
      $display("FAIL State_dbg: got %h expected %h", State_dbg, m_code());
    end
    checks++;
    if (Tms_Ones !== 3'(m_ones)) begin
      errors++;
      $display("FAIL Tms_Ones: got %0d expected %0d", Tms_Ones, m_ones);
    end
`endif
  endtask

  task automatic clr_counts();
    n_cap_dr = 0; n_sh_dr = 0; n_upd_dr = 0;
    n_cap_ir = 0; n_sh_ir = 0; n_upd_ir = 0;
    n_en = 0; n_sel = 0;
  endtask

  // One TCK cycle; entered and left just after a falling edge
  task automatic step(input bit t);
    bit prev_sel, prev_en;
    TMS = t;
    @(posedge TCK);
    prev_sel = m_sel();
    prev_en  = m_en();
    m_adv(t);
    #1;
    check_outputs(NEG ? prev_sel : m_sel(), NEG ? prev_en : m_en());
    n_cap_dr += int'(Capture_DR); n_sh_dr += int'(Shift_DR); n_upd_dr += int'(Update_DR);
    n_cap_ir += int'(Capture_IR); n_sh_ir += int'(Shift_IR); n_upd_ir += int'(Update_IR);
    @(negedge TCK);
    #1;
    check_outputs(m_sel(), m_en());
    n_en  += int'(TDO_En);
    n_sel += int'(Select);
  endtask

  task automatic seq(input logic [15:0] bits, input int len);
    for (int k = 0; k < len; k++) step(bits[k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Paths from TLR to each of the 16 states, TMS values LSB first
    path_len[0]  = 0; path_bits[0]  = 8'b0000000; // TLR
    path_len[1]  = 1; path_bits[1]  = 8'b0000000; // RTI
    path_len[2]  = 2; path_bits[2]  = 8'b0000010; // SelDR
    path_len[3]  = 3; path_bits[3]  = 8'b0000010; // CapDR
    path_len[4]  = 4; path_bits[4]  = 8'b0000010; // ShDR
    path_len[5]  = 4; path_bits[5]  = 8'b0001010; // Ex1DR
    path_len[6]  = 5; path_bits[6]  = 8'b0001010; // PauDR
    path_len[7]  = 6; path_bits[7]  = 8'b0101010; // Ex2DR
    path_len[8]  = 5; path_bits[8]  = 8'b0011010; // UpdDR
    path_len[9]  = 3; path_bits[9]  = 8'b0000110; // SelIR
    path_len[10] = 4; path_bits[10] = 8'b0000110; // CapIR
    path_len[11] = 5; path_bits[11] = 8'b0000110; // ShIR
    path_len[12] = 5; path_bits[12] = 8'b0010110; // Ex1IR
    path_len[13] = 6; path_bits[13] = 8'b0010110; // PauIR
    path_len[14] = 7; path_bits[14] = 8'b1010110; // Ex2IR
    path_len[15] = 6; path_bits[15] = 8'b0110110; // UpdIR

    // Reset: TRST_n low for 2 TCK
    TMS    = 1'b0;
    TRST_n = 1'b1;
    #2;
    TRST_n = 1'b0;
    m_reset();
    repeat (2) @(posedge TCK);
    @(negedge TCK);
    #1;
    check_outputs(1'b0, 1'b0);
    chk("reset_test_reset_lit", Test_Reset, 1'b1);
    TRST_n = 1'b1;
    step(1'b0);
    chk("rti_test_reset_lit", Test_Reset, 1'b0);

    // DR scan: 1,0,0,0,0,0,1,1,0
    clr_counts();
    seq(16'b0_1100_0001, 9);
    chk_int("dr_capture_count", n_cap_dr, 1);
    chk_int("dr_shift_count",   n_sh_dr,  4);
    chk_int("dr_update_count",  n_upd_dr, 1);
    chk_int("dr_tdo_en_count",  n_en,     4);
    chk_int("dr_select_count",  n_sel,    0);

    // IR scan: 1,1,0,0,0,0,0,1,1,0
    clr_counts();
    seq(16'b01_1000_0011, 10);
    chk_int("ir_capture_count", n_cap_ir, 1);
    chk_int("ir_shift_count",   n_sh_ir,  4);
    chk_int("ir_update_count",  n_upd_ir, 1);
    chk_int("ir_select_count",  n_sel,    7);
    chk("ir_select_back_rti", Select, 1'b0);

    // Pause and resume inside a DR shift
    seq(16'b001, 3);                  // RTI -> ShDR
    clr_counts();
    seq(16'b00_1001, 6);              // Ex1, Pau, Pau, Ex2, Sh, Sh
    chk_int("pause_shift_count",  n_sh_dr,  2);
    chk_int("pause_update_count", n_upd_dr, 0);
    seq(16'b011, 3);                  // Ex1, Upd, RTI

    // Five TMS=1 edges from every state reach TLR
    for (int s = 0; s < 16; s++) begin
      seq(16'h001F, 5);
      for (int k = 0; k < path_len[s]; k++) step(path_bits[s][k]);
      seq(16'h001F, 5);
      chk("five_ones_tlr_lit", Test_Reset, 1'b1);
`ifdef TAP_STATE_DEBUG_EN
      chk_int("five_ones_count_lit", int'(Tms_Ones), 5);
`endif
    end

    // Asynchronous TRST_n mid-ShIR, between TCK edges
    seq(16'b0_0110, 5);               // TLR -> RTI -> SelDR -> SelIR -> CapIR -> ShIR
    chk("shir_shift_lit",  Shift_IR, 1'b1);
    chk("shir_select_lit", Select,   1'b1);
    #2;
    TRST_n = 1'b0;
    #1;
    m_reset();
    check_outputs(1'b0, 1'b0);
    chk("trst_shift_ir_lit", Shift_IR, 1'b0);
    chk("trst_tdo_en_lit",   TDO_En,   1'b0);
    @(posedge TCK);
    #1;
    check_outputs(1'b0, 1'b0);
    @(negedge TCK);
    #1;
    check_outputs(1'b0, 1'b0);
    TRST_n = 1'b1;
    step(1'b0);
    step(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tap_fsm_ctrl.md
Name: tap_fsm_ctrl

Overview:
- IEEE 1149.1 TAP controller that sequences the JTAG scan datapath.
- Tracks the 16-state TAP machine from TMS.
- Drives the Select input of the TDO output multiplexer: 0 = data-register chain, 1 = instruction register.
- Generates capture/shift/update strobes for the IR and DR chains and the output-driver enable.

Parameters:
- TDO_NEG_EDGE, 1: 1 = Select and TDO_En registered on TCK falling edge (1149.1 timing); 0 = Select and TDO_En decoded combinationally from the current state.

Ports:
- TCK  input  1  test clock; the single clock.
- TRST_n  input  1  test reset; asynchronous, active-low.
- TMS  input  1  test mode select; sampled on TCK rising edge.
- Select  output  1  to output mux: 1 = IR path, 0 = DR path.
- TDO_En  output  1  output driver enable; high only while shifting.
- Capture_DR  output  1  DR parallel-load strobe.
- Shift_DR  output  1  DR shift enable.
- Update_DR  output  1  DR update strobe.
- Capture_IR  output  1  IR parallel-load strobe.
- Shift_IR  output  1  IR shift enable.
- Update_IR  output  1  IR update strobe.
- Test_Reset  output  1  high while in Test-Logic-Reset.

Behaviour:
- State register, 4 bits, advances on TCK rising edge.
- Encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- Transitions (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - SelIR: CapIR / TLR
  - CapDR, CapIR: Sh / Ex1
  - Sh: Sh / Ex1
  - Ex1: Pau / Upd
  - Pau: Pau / Ex2
  - Ex2: Sh / Upd
  - UpdDR, UpdIR: RTI / SelDR
- Any state reaches TLR after at most 5 consecutive TCK rising edges with TMS=1.
- TRST_n low: state forced to TLR immediately, independent of TCK.
  - Holds while low, including mid-shift; no partial strobe may follow.
- Decoded strobes are combinational from the state register, high for exactly the cycle(s) the state is held:
  - Capture_DR=(CapDR), Shift_DR=(ShDR), Update_DR=(UpdDR)
  - Capture_IR=(CapIR), Shift_IR=(ShIR), Update_IR=(UpdIR)
  - Test_Reset=(TLR)
- Select source term = state in {CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR}.
- TDO_En source term = state in {ShDR, ShIR}.
- TDO_NEG_EDGE=1:
  - Select and TDO_En are flops updated on TCK falling edge from the source terms.
  - They lag the state by half a TCK.
  - TRST_n low clears both asynchronously.
- TDO_NEG_EDGE=0: Select and TDO_En equal the source terms directly.
- Reset values of all outputs:
  - Test_Reset=1.
  - Select, TDO_En and all six strobes = 0.
- TMS X/Z while TRST_n high is a bench error; the RTL need not define behaviour for it.

Optional Feature:
- Macro TAP_STATE_DEBUG_EN.
- Defined:
  - Adds output port State_dbg, 4 bits, equal to the state register.
  - Adds output port Tms_Ones, 3 bits, counting consecutive TMS=1 samples.
    - Saturates at 5; clears on TMS=0 and on TRST_n low.
- Undefined: neither port exists; no counter logic is synthesised.

Test Plan:
- TRST_n=0 for 2 TCK, release, TMS=0 one edge -> Test_Reset 1 then 0; state RTI (C); all strobes 0.
- From RTI, TMS sequence 1,0,0,0,0,0,1,1,0 -> Capture_DR for 1 cycle, Shift_DR for 4 cycles, Update_DR for 1 cycle; Select=0 throughout; TDO_En high for the 4 shift cycles (half-cycle delayed when TDO_NEG_EDGE=1).
- From RTI, TMS 1,1,0,0,0,0,0,1,1,0 -> Capture_IR 1 cycle, Shift_IR 4 cycles, Update_IR 1 cycle; Select=1 from CapIR through UpdIR, back to 0 in RTI.
- From ShDR, TMS 1,0,0,1,0,0 (Pause then resume) -> Shift_DR drops during Ex1/Pau/Ex2, reasserts in ShDR; no Update_DR pulse.
- From each of the 16 states, TMS=1 for 5 edges -> state TLR, Test_Reset=1. With TAP_STATE_DEBUG_EN, Tms_Ones reads 5.
- TRST_n pulsed low mid-ShIR between TCK edges -> Shift_IR, Select, TDO_En drop without waiting for a TCK edge; state F.
